// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin scheduler sharing one SPI master transmitter among several packet sources
module spi_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_W     = 18,
    parameter int GAP_CYCLES = 12,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       send,
    output logic [DATA_W-1:0]          data_out,
    input  logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ-1:0]         done,
    output logic                       timeout_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(GAP_CYCLES + BUSY_WAIT + 2);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, GAP} state_t;
    state_t state;
    logic [NUM_REQ-1:0] full, full_nx;
    logic [DATA_W-1:0] slot [NUM_REQ];
    logic [IW-1:0] last_grant, pick, cand;
    logic [CW-1:0] cnt;
    logic any, grant;
    // Scan downward so the closest full slot after last_grant is the one left standing
    always_comb begin
        pick = last_grant;
        cand = last_grant;
        any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (full[cand]) begin
                pick = cand;
                any = 1'b1;
            end
        end
    end
    assign grant = (state == IDLE) && any && !busy;
    always_comb begin
        full_nx = full | (req_valid & req_ready);
        if (grant) full_nx[pick] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            full        <= '0;
            slot        <= '{default: '0};
            req_ready   <= '1;
            last_grant  <= IW'(NUM_REQ - 1);
            send        <= 1'b0;
            data_out    <= '0;
            grant_id    <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            full        <= full_nx;
            req_ready   <= ~full_nx;
            send        <= 1'b0;
            done        <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i]) slot[i] <= req_data[i*DATA_W +: DATA_W];
            case (state)
                IDLE: if (grant) begin
                    data_out   <= slot[pick];
                    grant_id   <= pick;
                    last_grant <= pick;
                    send       <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (busy) state <= XFER;
                else if (cnt == CW'(BUSY_WAIT - 1)) begin
                    timeout_err    <= 1'b1;
                    done[grant_id] <= 1'b1;
                    cnt            <= '0;
                    state          <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end else cnt <= cnt + 1'b1;
                XFER: if (!busy) begin
                    done[grant_id] <= 1'b1;
                    cnt            <= '0;
                    state          <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: if (cnt == CW'(GAP_CYCLES - 1)) state <= IDLE;
                else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed checks of slot handshake, round-robin order, link gap, busy timeout and reset
module tb_spi_tx_arbiter;
    localparam int N = 3;
    localparam int W = 18;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic busy = 1'b0;
    logic sel = 1'b0;
    logic [N-1:0] ready0, ready1, done0, done1, m_ready, m_done;
    logic send0, send1, to0, to1, m_send, m_to;
    logic [W-1:0] data0, data1, m_data;
    logic [1:0] gid0, gid1, m_gid;
    int total = 0, bad = 0;
    int cyc = 0, send_seen = 0, to_n = 0, rdy1_low = 0, viol = 0;
    int fall_cyc = 0, to_cyc = 0, sep = 0, auto_len = 0, busy_left = 0;
    int done_n [N];
    int d_cyc [N];
    logic [1:0] gq [$];
    logic [W-1:0] dq [$];
    int scyc [$];

    assign m_send  = sel ? send1 : send0;
    assign m_gid   = sel ? gid1 : gid0;
    assign m_data  = sel ? data1 : data0;
    assign m_done  = sel ? done1 : done0;
    assign m_ready = sel ? ready1 : ready0;
    assign m_to    = sel ? to1 : to0;

    always #5 clk = ~clk;

    spi_tx_arbiter dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready0), .send(send0), .data_out(data0), .busy(busy),
        .grant_id(gid0), .done(done0), .timeout_err(to0)
    );

    spi_tx_arbiter #(.GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready1), .send(send1), .data_out(data1), .busy(busy),
        .grant_id(gid1), .done(done1), .timeout_err(to1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setd(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    // One negedge: sample the selected DUT, then let the master model react
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (m_send && busy) viol++;
        if (m_send) begin
            send_seen++;
            gq.push_back(m_gid);
            dq.push_back(m_data);
            scyc.push_back(cyc);
            sep = cyc - fall_cyc;
        end
        for (int i = 0; i < N; i++)
            if (m_done[i]) begin
                done_n[i]++;
                d_cyc[i] = cyc;
            end
        if (m_to) begin
            to_n++;
            to_cyc = cyc;
        end
        if (!m_ready[1]) rdy1_low++;
        if (auto_len > 0) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    busy = 1'b0;
                    fall_cyc = cyc;
                end
            end else if (m_send) begin
                busy = 1'b1;
                busy_left = auto_len;
            end
        end
    endtask

    task automatic clr();
        send_seen = 0;
        to_n = 0;
        rdy1_low = 0;
        fall_cyc = 0;
        to_cyc = 0;
        sep = 0;
        done_n = '{default: 0};
        d_cyc = '{default: 0};
        gq.delete();
        dq.delete();
        scyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        busy = 1'b0;
        busy_left = 0;
        auto_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
    endtask

    task automatic run_until(input int n, input int lim, input string tag);
        int k = 0;
        while (send_seen < n && k < lim) begin
            tick();
            k++;
        end
        chk(tag, send_seen, n);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_send", 32'(send0), 0);
        chk("rst_data", 32'(data0), 0);
        chk("rst_gid", 32'(gid0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_timeout", 32'(to0), 0);
        chk("rst_ready", 32'(ready0), 7);
        rst_n = 1'b1;
        clr();

        auto_len = 40;
        setd(1, 18'h00141);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        chk("single_ready_low", 32'(ready0), 5);
        chk("single_send_early", 32'(send0), 0);
        tick();
        chk("single_send", 32'(send0), 1);
        chk("single_data", 32'(data0), 'h141);
        chk("single_gid", 32'(gid0), 1);
        chk("single_ready_back", 32'(ready0), 7);
        repeat (60) tick();
        chk("single_send_once", send_seen, 1);
        chk("single_done_once", done_n[1], 1);
        chk("single_done_others", done_n[0] + done_n[2], 0);
        chk("single_done_lat", d_cyc[1] - fall_cyc, 1);
        chk("single_ready_1cyc", rdy1_low, 1);
        chk("single_no_timeout", to_n, 0);

        do_reset();
        auto_len = 10;
        setd(0, 18'h100);
        setd(1, 18'h201);
        setd(2, 18'h302);
        req_valid = '1;
        run_until(6, 400, "rr_sends");
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            chk("rr_gid", 32'(gq[i]), i % 3);
            chk("rr_data", 32'(dq[i]), ((i % 3) + 1) * 256 + (i % 3));
        end

        do_reset();
        auto_len = 10;
        setd(0, 18'h0a0);
        setd(1, 18'h0b1);
        setd(2, 18'h0c2);
        req_valid = '1;
        tick();
        req_valid = '0;
        tick();
        chk("refill_first_send", 32'(send0), 1);
        chk("refill_first_gid", 32'(gid0), 0);
        setd(0, 18'h0d3);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        chk("refill_accept", 32'(ready0), 0);
        run_until(4, 300, "refill_sends");
        chk("refill_order1", 32'(gq[1]), 1);
        chk("refill_order2", 32'(gq[2]), 2);
        chk("refill_order3", 32'(gq[3]), 0);
        chk("refill_data3", 32'(dq[3]), 'h0d3);

        do_reset();
        auto_len = 20;
        setd(0, 18'h111);
        setd(1, 18'h222);
        req_valid = 3'b011;
        tick();
        req_valid = '0;
        run_until(2, 200, "gap12_sends");
        chk("gap12_spacing", sep, 14);
        chk("gap12_gid", 32'(gq[1]), 1);

        sel = 1'b1;
        do_reset();
        auto_len = 20;
        req_valid = 3'b011;
        tick();
        req_valid = '0;
        run_until(2, 200, "gap0_sends");
        chk("gap0_spacing", sep, 2);
        chk("gap0_data", 32'(dq[1]), 'h222);
        sel = 1'b0;

        do_reset();
        setd(0, 18'h0f0);
        setd(1, 18'h0f1);
        req_valid = 3'b011;
        tick();
        req_valid = '0;
        run_until(2, 200, "timeout_sends");
        chk("timeout_lat", to_cyc - scyc[0], 5);
        chk("timeout_done_lat", d_cyc[0] - scyc[0], 5);
        chk("timeout_done0", done_n[0], 1);
        chk("timeout_next", scyc[1] - to_cyc, 13);
        chk("timeout_count", to_n, 1);
        chk("timeout_gid", 32'(gq[1]), 1);

        do_reset();
        auto_len = 30;
        setd(0, 18'h010);
        setd(1, 18'h121);
        setd(2, 18'h232);
        req_valid = '1;
        tick();
        req_valid = '0;
        tick();
        repeat (5) tick();
        chk("rmid_pre_ready", 32'(ready0), 1);
        chk("rmid_pre_data", 32'(data0), 'h010);
        rst_n = 1'b0;
        #1;
        chk("rmid_data", 32'(data0), 0);
        chk("rmid_gid", 32'(gid0), 0);
        chk("rmid_ready", 32'(ready0), 7);
        chk("rmid_done", 32'(done0), 0);
        chk("rmid_send", 32'(send0), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rmid_nosend", send_seen, 1);
        chk("rmid_nodone", done_n[0] + done_n[1] + done_n[2], 0);
        setd(2, 18'h2ee);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        run_until(2, 100, "rmid_sends");
        chk("rmid_wait_busy", sep, 1);
        chk("rmid_new_gid", 32'(gq[1]), 2);
        chk("rmid_new_data", 32'(dq[1]), 'h2ee);
        chk("send_while_busy", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
